// File: rtl/pool_bin_pkg.sv
// Shared widths, layer encodings and the signed max helper for the pool/binarise stage.
package pool_bin_pkg;

  localparam int unsigned DW       = 5;
  localparam int unsigned W0       = 26;
  localparam int unsigned W1       = 8;
  localparam int unsigned CW       = $clog2(W0);
  localparam int unsigned LB_DEPTH = (W0 + 1) / 2;
  localparam int unsigned AW       = $clog2(LB_DEPTH);

  localparam logic CONV_L1 = 1'b0;
  localparam logic CONV_L2 = 1'b1;

  localparam logic signed [DW-1:0] THRESH = '0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                input logic signed [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_bin_if.sv
// Conv result stream in, pooled/binarised stream out.
interface pool_bin_if;
  import pool_bin_pkg::*;

  logic                 start;
  logic                 state;
  logic signed [DW-1:0] din;
  logic                 ivalid;
  logic                 idone;
  logic signed [DW-1:0] dout_max;
  logic                 dout_bin;
  logic                 ovalid;
  logic                 done;
  logic                 err;

  modport master (
    output start, state, din, ivalid, idone,
    input  dout_max, dout_bin, ovalid, done, err
  );

  modport slave (
    input  start, state, din, ivalid, idone,
    output dout_max, dout_bin, ovalid, done, err
  );

endinterface

// File: rtl/pool_bin_lbuf.sv
// Half-row line buffer: even rows deposit pair maxima, odd rows read them back.
module pool_lbuf
  import pool_bin_pkg::*;
(
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [AW-1:0]        i_waddr,
  input  logic signed [DW-1:0] i_wdata,
  input  logic [AW-1:0]        i_raddr,
  output logic signed [DW-1:0] o_rdata_c
);

  logic signed [DW-1:0] r_mem [LB_DEPTH];

  // Contents are always written on an even row before the odd row reads them.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata_c = r_mem[i_raddr];

endmodule

// File: rtl/pool_bin.sv
// 2x2 stride-2 max-pool with sign binarisation over conv's row-major result stream.
module pool_bin
  import pool_bin_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  pool_bin_if.slave  bus
);

  state_e               r_state, w_state_n;
  logic                 r_start_q;
  logic [CW-1:0]        r_wm1, w_wm1_n;
  logic [CW-1:0]        r_col, w_col_n;
  logic [CW-1:0]        r_row, w_row_n;
  logic signed [DW-1:0] r_pair, w_pair_n;
  logic signed [DW-1:0] r_dout_max, w_dout_max_n;
  logic                 r_dout_bin, w_dout_bin_n;
  logic                 r_ovalid, w_ovalid_n;
  logic                 r_done, w_done_n;
  logic                 r_err, w_err_n;

  logic                 w_start_edge;
  logic                 w_last;
  logic                 w_lb_we;
  logic [AW-1:0]        w_lb_idx;
  logic signed [DW-1:0] w_lb_rdata;
  logic signed [DW-1:0] w_pmax;
  logic signed [DW-1:0] w_wmax;

  assign w_start_edge = bus.start & ~r_start_q;
  assign w_last       = (r_row == r_wm1) && (r_col == r_wm1);
  assign w_lb_idx     = r_col[CW-1:1];
  assign w_pmax       = smax(r_pair, bus.din);
  assign w_wmax       = smax(w_lb_rdata, w_pmax);

  pool_lbuf u_lbuf (
    .clk       (clk),
    .i_we      (w_lb_we),
    .i_waddr   (w_lb_idx),
    .i_wdata   (w_pmax),
    .i_raddr   (w_lb_idx),
    .o_rdata_c (w_lb_rdata)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_start_q  <= 1'b0;
      r_wm1      <= CW'(W0 - 1);
      r_col      <= '0;
      r_row      <= '0;
      r_pair     <= '0;
      r_dout_max <= '0;
      r_dout_bin <= 1'b0;
      r_ovalid   <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_start_q  <= bus.start;
      r_wm1      <= w_wm1_n;
      r_col      <= w_col_n;
      r_row      <= w_row_n;
      r_pair     <= w_pair_n;
      r_dout_max <= w_dout_max_n;
      r_dout_bin <= w_dout_bin_n;
      r_ovalid   <= w_ovalid_n;
      r_done     <= w_done_n;
      r_err      <= w_err_n;
    end
  end

  always_comb begin
    w_state_n    = r_state;
    w_wm1_n      = r_wm1;
    w_col_n      = r_col;
    w_row_n      = r_row;
    w_pair_n     = r_pair;
    w_dout_max_n = r_dout_max;
    w_dout_bin_n = r_dout_bin;
    w_ovalid_n   = 1'b0;
    w_done_n     = 1'b0;
    w_err_n      = r_err;
    w_lb_we      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.ivalid) w_err_n = 1'b1;
        if (w_start_edge) begin
          w_state_n = ST_RUN;
          w_wm1_n   = (bus.state == CONV_L1) ? CW'(W0 - 1) : CW'(W1 - 1);
          w_col_n   = '0;
          w_row_n   = '0;
        end
      end

      ST_RUN: begin
        if (bus.ivalid) begin
          if (bus.idone != w_last) w_err_n = 1'b1;

          // Even col parks the pixel; odd col folds it into the row pair or the window.
          if (!r_col[0]) begin
            w_pair_n = bus.din;
          end else if (!r_row[0]) begin
            w_lb_we = 1'b1;
          end else begin
            w_dout_max_n = w_wmax;
            w_dout_bin_n = (w_wmax >= THRESH);
            w_ovalid_n   = 1'b1;
          end

          if (w_last) begin
            w_col_n   = '0;
            w_row_n   = '0;
            w_done_n  = 1'b1;
            w_state_n = ST_IDLE;
          end else if (r_col == r_wm1) begin
            w_col_n = '0;
            w_row_n = r_row + CW'(1);
          end else begin
            w_col_n = r_col + CW'(1);
          end
        end
      end

      default: w_state_n = ST_IDLE;
    endcase
  end

  assign bus.dout_max = r_dout_max;
  assign bus.dout_bin = r_dout_bin;
  assign bus.ovalid   = r_ovalid;
  assign bus.done     = r_done;
  assign bus.err      = r_err;

endmodule

// File: tb/tb_pool_bin.sv
// Scoreboard bench for pool_bin: driver pushes reference window maxima, monitor pops on ovalid.
module tb_pool_bin;
  import pool_bin_pkg::*;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  pool_bin_if bus();

  pool_bin dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    logic signed [DW-1:0] mx;
    logic                 bn;
    logic                 dn;
    time                  t;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_ov    = 0;
  int   n_done  = 0;
  int   n_bin1  = 0;
  logic signed [DW-1:0] last_max;
  logic                 last_bin;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pix(input int sel, input int r, input int c);
    case (sel)
      0:       return ((r * 26 + c) % 16) - 8;
      1:       return (r == 3 && c == 5) ? 15 : -16;
      default: return (((r * 8 + c) * 5) % 32) - 16;
    endcase
  endfunction

  // Monitor: every ovalid must match the oldest queued window, exactly half a clock after its 4th beat.
  always @(negedge clk) begin
    if (rstn) begin
      if (bus.ovalid) begin
        n_ov++;
        if (bus.done) n_done++;
        if (bus.dout_bin) n_bin1++;
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_ovalid: got dout_max=%0d with empty queue (t=%0t)",
                   bus.dout_max, $time);
        end else begin
          mon_e = q.pop_front();
          chk("dout_max", int'(bus.dout_max), int'(mon_e.mx));
          chk("dout_bin", int'(bus.dout_bin), int'(mon_e.bn));
          chk("done",     int'(bus.done),     int'(mon_e.dn));
          chk("latency",  int'($time - mon_e.t), 5);
        end
      end else if (bus.done) begin
        n_tests++;
        n_fail++;
        $display("FAIL done_without_ovalid: got done=1 ovalid=0 (t=%0t)", $time);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_map(input int mode, input int sel, input int max_gap,
                         input int bad_idone, input int abort_at, input bit toggle);
    int   w, n, r, c, m, a;
    exp_t e;
    w = (mode != 0) ? 8 : 26;
    n = w * w;
    bus.start = 1'b1;
    bus.state = mode[0];
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < n; i++) begin
      r = i / w;
      c = i % w;
      if (i == abort_at) begin
        rstn = 1'b0;
        return;
      end
      bus.din    = DW'(pix(sel, r, c));
      bus.ivalid = 1'b1;
      bus.idone  = (i == n - 1) || (i == bad_idone);
      if (toggle) bus.state = ~bus.state;
      @(posedge clk);
      if ((r % 2 == 1) && (c % 2 == 1)) begin
        m = pix(sel, r, c);
        a = pix(sel, r - 1, c - 1); if (a > m) m = a;
        a = pix(sel, r - 1, c);     if (a > m) m = a;
        a = pix(sel, r, c - 1);     if (a > m) m = a;
        e.mx = DW'(m);
        e.bn = (m >= 0);
        e.dn = (i == n - 1);
        e.t  = $time;
        q.push_back(e);
        last_max = e.mx;
        last_bin = e.bn;
      end
      #1;
      bus.ivalid = 1'b0;
      bus.idone  = 1'b0;
      if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) tick();
    end
    repeat (2) tick();
  endtask

  task automatic scen_check(input string name, input int exp_ov, input int exp_done,
                            input int exp_err);
    chk({name, "_ovalid_count"}, n_ov, exp_ov);
    chk({name, "_done_count"},   n_done, exp_done);
    chk({name, "_queue_left"},   q.size(), 0);
    chk({name, "_err"},          int'(bus.err), exp_err);
    n_ov   = 0;
    n_done = 0;
    n_bin1 = 0;
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_dout_max"}, int'(bus.dout_max), 0);
    chk({name, "_dout_bin"}, int'(bus.dout_bin), 0);
    chk({name, "_ovalid"},   int'(bus.ovalid), 0);
    chk({name, "_done"},     int'(bus.done), 0);
    chk({name, "_err"},      int'(bus.err), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got t=%0t", $time);
    $display("[TB] %0d tests run, %0d failed", n_tests + 1, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start  = 1'b0;
    bus.state  = 1'b0;
    bus.din    = '0;
    bus.ivalid = 1'b0;
    bus.idone  = 1'b0;
    last_max   = '0;
    last_bin   = 1'b0;

    #23;
    chk_reset_outputs("reset");
    tick();
    rstn = 1'b1;
    tick();

    // 26x26 ramp
    run_map(0, 0, 0, -1, -1, 1'b0);
    scen_check("s1", 169, 1, 0);

    // 8x8 single positive pixel; outputs hold afterwards
    run_map(1, 1, 0, -1, -1, 1'b0);
    chk("s2_bin_ones", n_bin1, 1);
    scen_check("s2", 16, 1, 0);
    repeat (3) tick();
    chk("s2_hold_max", int'(bus.dout_max), int'(last_max));
    chk("s2_hold_bin", int'(bus.dout_bin), int'(last_bin));
    chk("s2_hold_ovalid", int'(bus.ovalid), 0);

    // ramp with random idle gaps
    run_map(0, 0, 3, -1, -1, 1'b0);
    scen_check("s3", 169, 1, 0);

    // back-to-back maps, state toggled while running
    run_map(0, 0, 0, -1, -1, 1'b1);
    run_map(1, 2, 0, -1, -1, 1'b1);
    scen_check("s6", 185, 2, 0);

    // early idone
    run_map(0, 0, 0, 100, -1, 1'b0);
    scen_check("s4a", 169, 1, 1);

    // reset mid-map, then a clean re-run
    run_map(0, 0, 0, -1, 300, 1'b0);
    #2;
    chk_reset_outputs("s5_abort");
    chk("s5_abort_done_count", n_done, 0);
    q.delete();
    tick();
    rstn = 1'b1;
    tick();
    n_ov   = 0;
    n_done = 0;
    run_map(0, 0, 0, -1, -1, 1'b0);
    scen_check("s5", 169, 1, 0);

    // ivalid while idle
    bus.din    = DW'(5);
    bus.ivalid = 1'b1;
    repeat (3) tick();
    bus.ivalid = 1'b0;
    repeat (2) tick();
    scen_check("s4b", 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
